// File: rtl/matmul_tag_pipe_if.sv
// Clock/reset bundle shared by the fixed-point datapath blocks.
// Latency: none (wiring only).
// Backpressure: none; carries the matmul latency used to seed tag pipes.
interface fixedp #(
    parameter int MATMUL_LAT = 4
);
    logic clk;
    logic reset;

    modport sink (input clk, input reset);
endinterface

// File: rtl/matmul_tag_pipe.sv
// Delays a valid vector plus sideband tag by a runtime latency (0..MAX_DELAY).
// Latency: lat_cur advancing cycles; lat_cur=0 is a combinational bypass.
// Backpressure: en=0 freezes all stages and masks the output; flush drops everything.
module matmul_tag_pipe #(
    parameter int WIDTH       = 1,
    parameter int TAG_W       = 8,
    parameter int MAX_DELAY   = 16,
    parameter int DEFAULT_LAT = 4,
    localparam int LW         = $clog2(MAX_DELAY + 1)
) (
    fixedp.sink              g,
    input  logic             en,
    input  logic             flush,
    input  logic [LW-1:0]    lat,
    input  logic [WIDTH-1:0] i_valid,
    input  logic [TAG_W-1:0] i_tag,
    output logic [WIDTH-1:0] o_valid,
    output logic [TAG_W-1:0] o_tag,
    output logic [LW-1:0]    count,
    output logic             busy,
    output logic [LW-1:0]    lat_cur,
    output logic             lat_pending,
    output logic             lat_err
);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_DELAY);

    logic [WIDTH-1:0] r_vld [1:MAX_DELAY];
    logic [TAG_W-1:0] r_tag [1:MAX_DELAY];
    logic [LW-1:0]    r_lat_cur;
    logic [LW-1:0]    r_count;
    logic             r_lat_err;

    logic [LW-1:0]    w_lat_req;
    logic [WIDTH-1:0] w_tap_vld;
    logic [TAG_W-1:0] w_tap_tag;
    logic             w_acc;
    logic             w_inc;
    logic             w_dec;
    logic [LW-1:0]    w_cnt_base;
    logic             w_switch;
    logic [LW-1:0]    w_lat_eff;
    logic [LW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_in_vld;

    assign w_lat_req = (lat > MAX_L) ? MAX_L : lat;

    // Select the output tap: stage[lat_cur], or the live input when latency is zero.
    always_comb begin
        w_tap_vld = i_valid;
        w_tap_tag = i_tag;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (r_lat_cur == LW'(k)) begin
                w_tap_vld = r_vld[k];
                w_tap_tag = r_tag[k];
            end
        end
    end

    assign o_valid = w_tap_vld & {WIDTH{en}};
    assign o_tag   = (|o_valid) ? w_tap_tag : '0;

    // Only nonzero valid vectors are entries; bubbles never touch the count.
    assign w_acc = en & ~flush & (|i_valid);
    assign w_inc = w_acc & (r_lat_cur != '0);
    assign w_dec = en & (r_lat_cur != '0) & (|w_tap_vld);

    // Occupancy after this edge, before any latency switch is considered.
    always_comb begin
        w_cnt_base = r_count;
        if (flush) begin
            w_cnt_base = '0;
        end else if (w_inc && !w_dec) begin
            w_cnt_base = r_count + LW'(1);
        end else if (!w_inc && w_dec) begin
            w_cnt_base = r_count - LW'(1);
        end
    end

    // Switch latency only when the pipe drains; an entry taken on a 0->N switch
    // edge rides the new latency, so it must be counted as in flight.
    assign w_switch   = (w_cnt_base == '0);
    assign w_lat_eff  = w_switch ? w_lat_req : r_lat_cur;
    assign w_cnt_next = (w_switch && w_acc && (w_lat_eff != '0)) ? LW'(1) : w_cnt_base;
    assign w_in_vld   = (w_lat_eff != '0) ? i_valid : '0;

    // Stage shift register; stages past the tap are zeroed so consumed entries cannot reappear.
    always_ff @(posedge g.clk) begin
        if (g.reset) begin
            for (int k = 1; k <= MAX_DELAY; k++) begin
                r_vld[k] <= '0;
                r_tag[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 1; k <= MAX_DELAY; k++) begin
                r_vld[k] <= '0;
            end
        end else if (en) begin
            r_vld[1] <= w_in_vld;
            r_tag[1] <= i_tag;
            for (int k = 1; k < MAX_DELAY; k++) begin
                r_vld[k+1] <= (LW'(k) < r_lat_cur) ? r_vld[k] : '0;
                r_tag[k+1] <= r_tag[k];
            end
        end
    end

    // Occupancy, active latency and the sticky out-of-range flag.
    always_ff @(posedge g.clk) begin
        if (g.reset) begin
            r_count   <= '0;
            r_lat_cur <= LW'(DEFAULT_LAT);
            r_lat_err <= 1'b0;
        end else begin
            r_count   <= w_cnt_next;
            r_lat_cur <= w_lat_eff;
            if (lat > MAX_L) begin
                r_lat_err <= 1'b1;
            end
        end
    end

    assign count       = r_count;
    assign busy        = (r_count != '0);
    assign lat_cur     = r_lat_cur;
    assign lat_pending = (w_lat_req != r_lat_cur);
    assign lat_err     = r_lat_err;
endmodule

// File: tb/tb_matmul_tag_pipe.sv
// Directed bench for matmul_tag_pipe: latency, stalls, latency switching, flush, reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 1 unit later.
// Backpressure: en toggled directly by the stimulus tables.
module tb_matmul_tag_pipe;
    localparam int W    = 2;
    localparam int TW   = 8;
    localparam int MD   = 16;
    localparam int LAT0 = 4;
    localparam int LW   = $clog2(MD + 1);

    fixedp #(.MATMUL_LAT(LAT0)) g_if ();

    logic          en;
    logic          flush;
    logic [LW-1:0] lat;
    logic [W-1:0]  i_valid;
    logic [TW-1:0] i_tag;
    logic [W-1:0]  o_valid;
    logic [TW-1:0] o_tag;
    logic [LW-1:0] count;
    logic          busy;
    logic [LW-1:0] lat_cur;
    logic          lat_pending;
    logic          lat_err;

    int n_chk  = 0;
    int n_fail = 0;

    matmul_tag_pipe #(
        .WIDTH(W), .TAG_W(TW), .MAX_DELAY(MD), .DEFAULT_LAT(LAT0)
    ) dut (
        .g(g_if.sink), .en(en), .flush(flush), .lat(lat),
        .i_valid(i_valid), .i_tag(i_tag), .o_valid(o_valid), .o_tag(o_tag),
        .count(count), .busy(busy), .lat_cur(lat_cur),
        .lat_pending(lat_pending), .lat_err(lat_err)
    );

    initial g_if.clk = 1'b0;
    always #5 g_if.clk = ~g_if.clk;

    task automatic drive(input logic e, input logic f, input logic [LW-1:0] l,
                         input logic [W-1:0] v, input logic [TW-1:0] t);
        en = e; flush = f; lat = l; i_valid = v; i_tag = t;
        #1;
    endtask

    task automatic tick();
        @(posedge g_if.clk);
        #1;
    endtask

    task automatic test_reset();
        g_if.reset = 1'b1;
        drive(1'b1, 1'b0, 5'd4, 2'b00, 8'h00);
        tick();
        tick();
        g_if.reset = 1'b0;
        drive(1'b1, 1'b0, 5'd4, 2'b00, 8'h00);
        n_chk++; if (o_valid !== 2'b00) begin n_fail++; $display("FAIL reset_o_valid got %h exp 0", o_valid); end
        n_chk++; if (o_tag !== 8'h00) begin n_fail++; $display("FAIL reset_o_tag got %h exp 0", o_tag); end
        n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_chk++; if (lat_cur !== 5'd4) begin n_fail++; $display("FAIL reset_lat_cur got %0d exp 4", lat_cur); end
        n_chk++; if (lat_err !== 1'b0) begin n_fail++; $display("FAIL reset_lat_err got %b exp 0", lat_err); end
        n_chk++; if (lat_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending4 got %b exp 0", lat_pending); end
        drive(1'b1, 1'b0, 5'd9, 2'b00, 8'h00);
        n_chk++; if (lat_pending !== 1'b1) begin n_fail++; $display("FAIL reset_pending9 got %b exp 1", lat_pending); end
        drive(1'b1, 1'b0, 5'd4, 2'b00, 8'h00);
        tick();
    endtask

    task automatic test_basic();
        int ecnt [0:9];
        logic [TW-1:0] tg, et;
        logic [W-1:0] ev;
        ecnt = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 0};
        for (int c = 0; c < 10; c++) begin
            tg = (c == 0) ? 8'h11 : (c == 1) ? 8'h22 : (c == 2) ? 8'h33 : 8'h00;
            drive(1'b1, 1'b0, 5'd4, (c < 3) ? 2'b01 : 2'b00, tg);
            ev = (c >= 4 && c <= 6) ? 2'b01 : 2'b00;
            et = (c == 4) ? 8'h11 : (c == 5) ? 8'h22 : (c == 6) ? 8'h33 : 8'h00;
            n_chk++; if (o_valid !== ev) begin n_fail++; $display("FAIL basic_valid c=%0d got %h exp %h", c, o_valid, ev); end
            n_chk++; if (o_tag !== et) begin n_fail++; $display("FAIL basic_tag c=%0d got %h exp %h", c, o_tag, et); end
            n_chk++; if (count !== LW'(ecnt[c])) begin n_fail++; $display("FAIL basic_count c=%0d got %0d exp %0d", c, count, ecnt[c]); end
            n_chk++; if (busy !== (ecnt[c] != 0)) begin n_fail++; $display("FAIL basic_busy c=%0d got %b", c, busy); end
            tick();
        end
    endtask

    task automatic test_stall();
        int ecnt [0:9];
        logic [TW-1:0] tg, et;
        logic [W-1:0] ev, iv;
        ecnt = '{0, 1, 2, 2, 3, 3, 3, 2, 1, 0};
        for (int c = 0; c < 10; c++) begin
            tg = (c == 0) ? 8'h11 : (c == 1) ? 8'h22 : (c == 2 || c == 3) ? 8'h33 : 8'h00;
            iv = (c <= 3) ? 2'b01 : 2'b00;
            drive(!(c == 2 || c == 5), 1'b0, 5'd4, iv, tg);
            ev = (c >= 6 && c <= 8) ? 2'b01 : 2'b00;
            et = (c == 6) ? 8'h11 : (c == 7) ? 8'h22 : (c == 8) ? 8'h33 : 8'h00;
            n_chk++; if (o_valid !== ev) begin n_fail++; $display("FAIL stall_valid c=%0d got %h exp %h", c, o_valid, ev); end
            n_chk++; if (o_tag !== et) begin n_fail++; $display("FAIL stall_tag c=%0d got %h exp %h", c, o_tag, et); end
            n_chk++; if (count !== LW'(ecnt[c])) begin n_fail++; $display("FAIL stall_count c=%0d got %0d exp %0d", c, count, ecnt[c]); end
            tick();
        end
    endtask

    task automatic test_lat_switch();
        int ecnt;
        logic [TW-1:0] tg, et;
        logic [W-1:0] ev, iv;
        logic [LW-1:0] elc;
        for (int c = 0; c < 17; c++) begin
            iv = (c == 0) ? 2'b01 : (c == 1) ? 2'b11 : (c == 6) ? 2'b01 : 2'b00;
            tg = (c == 0) ? 8'h41 : (c == 1) ? 8'h42 : (c == 6) ? 8'hB0 : 8'h00;
            drive(1'b1, 1'b0, (c == 0) ? 5'd4 : 5'd8, iv, tg);
            ev = (c == 4) ? 2'b01 : (c == 5) ? 2'b11 : (c == 14) ? 2'b01 : 2'b00;
            et = (c == 4) ? 8'h41 : (c == 5) ? 8'h42 : (c == 14) ? 8'hB0 : 8'h00;
            ecnt = (c == 0) ? 0 : (c == 1) ? 1 : (c <= 4) ? 2 : (c == 5) ? 1 : (c == 6) ? 0 : (c <= 14) ? 1 : 0;
            elc = (c <= 5) ? 5'd4 : 5'd8;
            n_chk++; if (o_valid !== ev) begin n_fail++; $display("FAIL sw_valid c=%0d got %h exp %h", c, o_valid, ev); end
            n_chk++; if (o_tag !== et) begin n_fail++; $display("FAIL sw_tag c=%0d got %h exp %h", c, o_tag, et); end
            n_chk++; if (count !== LW'(ecnt)) begin n_fail++; $display("FAIL sw_count c=%0d got %0d exp %0d", c, count, ecnt); end
            n_chk++; if (lat_cur !== elc) begin n_fail++; $display("FAIL sw_lat_cur c=%0d got %0d exp %0d", c, lat_cur, elc); end
            n_chk++; if (lat_pending !== (c >= 1 && c <= 5)) begin n_fail++; $display("FAIL sw_pending c=%0d got %b", c, lat_pending); end
            tick();
        end
    endtask

    task automatic test_lat0_err();
        drive(1'b1, 1'b0, 5'd0, 2'b00, 8'h00);
        n_chk++; if (lat_pending !== 1'b1) begin n_fail++; $display("FAIL z_pending got %b exp 1", lat_pending); end
        tick();
        drive(1'b1, 1'b0, 5'd0, 2'b01, 8'h5A);
        n_chk++; if (lat_cur !== 5'd0) begin n_fail++; $display("FAIL z_lat_cur got %0d exp 0", lat_cur); end
        n_chk++; if (o_valid !== 2'b01) begin n_fail++; $display("FAIL z_valid1 got %h exp 01", o_valid); end
        n_chk++; if (o_tag !== 8'h5A) begin n_fail++; $display("FAIL z_tag1 got %h exp 5a", o_tag); end
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b11, 8'hC3);
        n_chk++; if (o_valid !== 2'b00) begin n_fail++; $display("FAIL z_stall_valid got %h exp 0", o_valid); end
        n_chk++; if (o_tag !== 8'h00) begin n_fail++; $display("FAIL z_stall_tag got %h exp 0", o_tag); end
        tick();
        drive(1'b1, 1'b0, 5'd0, 2'b10, 8'h3C);
        n_chk++; if (o_valid !== 2'b10) begin n_fail++; $display("FAIL z_valid2 got %h exp 10", o_valid); end
        n_chk++; if (o_tag !== 8'h3C) begin n_fail++; $display("FAIL z_tag2 got %h exp 3c", o_tag); end
        tick();
        drive(1'b1, 1'b0, 5'd0, 2'b00, 8'h77);
        n_chk++; if (o_tag !== 8'h00) begin n_fail++; $display("FAIL z_bubble_tag got %h exp 0", o_tag); end
        n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL z_count got %0d exp 0", count); end
        tick();
        drive(1'b1, 1'b0, 5'd19, 2'b00, 8'h00);
        n_chk++; if (lat_pending !== 1'b1) begin n_fail++; $display("FAIL e_pending got %b exp 1", lat_pending); end
        n_chk++; if (lat_err !== 1'b0) begin n_fail++; $display("FAIL e_err_pre got %b exp 0", lat_err); end
        tick();
        drive(1'b1, 1'b0, 5'd19, 2'b00, 8'h00);
        n_chk++; if (lat_err !== 1'b1) begin n_fail++; $display("FAIL e_err got %b exp 1", lat_err); end
        n_chk++; if (lat_cur !== 5'd16) begin n_fail++; $display("FAIL e_lat_cur got %0d exp 16", lat_cur); end
        n_chk++; if (lat_pending !== 1'b0) begin n_fail++; $display("FAIL e_pending_clamp got %b exp 0", lat_pending); end
        tick();
        drive(1'b1, 1'b0, 5'd4, 2'b00, 8'h00);
        tick();
        drive(1'b1, 1'b0, 5'd4, 2'b00, 8'h00);
        n_chk++; if (lat_err !== 1'b1) begin n_fail++; $display("FAIL e_err_sticky got %b exp 1", lat_err); end
        n_chk++; if (lat_cur !== 5'd4) begin n_fail++; $display("FAIL e_lat_back got %0d exp 4", lat_cur); end
        tick();
    endtask

    task automatic test_flush();
        int ecnt;
        logic [TW-1:0] tg, et;
        logic [W-1:0] ev, iv;
        for (int c = 0; c < 13; c++) begin
            iv = (c <= 2 || c == 4) ? 2'b01 : 2'b00;
            tg = (c == 0) ? 8'h61 : (c == 1) ? 8'h62 : (c == 2) ? 8'h63 : (c == 4) ? 8'h64 : 8'h00;
            drive(1'b1, (c == 4), 5'd4, iv, tg);
            ev = (c == 4) ? 2'b01 : 2'b00;
            et = (c == 4) ? 8'h61 : 8'h00;
            ecnt = (c <= 3) ? c : (c == 4) ? 3 : 0;
            n_chk++; if (o_valid !== ev) begin n_fail++; $display("FAIL fl_valid c=%0d got %h exp %h", c, o_valid, ev); end
            n_chk++; if (o_tag !== et) begin n_fail++; $display("FAIL fl_tag c=%0d got %h exp %h", c, o_tag, et); end
            n_chk++; if (count !== LW'(ecnt)) begin n_fail++; $display("FAIL fl_count c=%0d got %0d exp %0d", c, count, ecnt); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 5'd6, 2'b00, 8'h00);
        tick();
        for (int c = 0; c < 12; c++) begin
            g_if.reset = (c == 2);
            drive((c != 2), (c == 2), 5'd6, (c <= 1) ? 2'b01 : 2'b00, (c == 0) ? 8'h71 : 8'h72);
            if (c == 3) begin
                n_chk++; if (lat_cur !== 5'd4) begin n_fail++; $display("FAIL rm_lat_cur got %0d exp 4", lat_cur); end
                n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL rm_count got %0d exp 0", count); end
            end
            n_chk++; if (o_valid !== 2'b00) begin n_fail++; $display("FAIL rm_valid c=%0d got %h exp 0", c, o_valid); end
            tick();
        end
        g_if.reset = 1'b0;
    endtask

    task automatic test_shrink_grow();
        int ecnt;
        logic [TW-1:0] tg, et;
        logic [W-1:0] ev, iv;
        logic [LW-1:0] elc, lreq;
        drive(1'b1, 1'b0, 5'd8, 2'b00, 8'h00);
        tick();
        for (int c = 0; c < 27; c++) begin
            iv = (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : (c == 10) ? 2'b01 : (c == 11) ? 2'b11 : (c == 16) ? 2'b01 : 2'b00;
            tg = (c == 0) ? 8'h81 : (c == 1) ? 8'h82 : (c == 10) ? 8'h91 : (c == 11) ? 8'h92 : (c == 16) ? 8'hA5 : 8'h00;
            lreq = (c <= 1) ? 5'd8 : (c <= 12) ? 5'd2 : 5'd8;
            drive(1'b1, 1'b0, lreq, iv, tg);
            ev = (c == 8) ? 2'b01 : (c == 9) ? 2'b10 : (c == 12) ? 2'b01 : (c == 13) ? 2'b11 : (c == 24) ? 2'b01 : 2'b00;
            et = (c == 8) ? 8'h81 : (c == 9) ? 8'h82 : (c == 12) ? 8'h91 : (c == 13) ? 8'h92 : (c == 24) ? 8'hA5 : 8'h00;
            elc = (c <= 9) ? 5'd8 : (c <= 13) ? 5'd2 : 5'd8;
            ecnt = (c == 0) ? 0 : (c == 1) ? 1 : (c <= 8) ? 2 : (c == 9) ? 1 : (c == 10) ? 0 :
                   (c == 11) ? 1 : (c == 12) ? 2 : (c == 13) ? 1 : (c <= 16) ? 0 : (c <= 24) ? 1 : 0;
            n_chk++; if (o_valid !== ev) begin n_fail++; $display("FAIL sg_valid c=%0d got %h exp %h", c, o_valid, ev); end
            n_chk++; if (o_tag !== et) begin n_fail++; $display("FAIL sg_tag c=%0d got %h exp %h", c, o_tag, et); end
            n_chk++; if (lat_cur !== elc) begin n_fail++; $display("FAIL sg_lat_cur c=%0d got %0d exp %0d", c, lat_cur, elc); end
            n_chk++; if (count !== LW'(ecnt)) begin n_fail++; $display("FAIL sg_count c=%0d got %0d exp %0d", c, count, ecnt); end
            tick();
        end
    endtask

    initial begin
        g_if.reset = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_lat_switch();
        test_lat0_err();
        test_flush();
        test_reset_mid();
        test_shrink_grow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/matmul_tag_pipe.md
# matmul_tag_pipe

Runtime-configurable valid/tag matching pipe for the fixed-point datapath. It delays a WIDTH-bit valid vector plus a TAG_W-bit sideband tag by a selectable number of advancing cycles (0..MAX_DELAY), so results of variable-latency units (matmul, add, activation) stay aligned with their tags. Over a fixed valid pipe it adds:

- stall (`en`) support
- synchronous flush
- in-flight occupancy tracking
- safe latency switching only when the pipe is empty

## Interface
Parameters:
- WIDTH, 1, valid bits per entry
- TAG_W, 8, sideband tag width
- MAX_DELAY, 16, deepest supported latency (≥1)
- DEFAULT_LAT, 4, latency loaded at reset; instantiations pass g.MATMUL_LAT; must be ≤ MAX_DELAY

Ports (clock and reset arrive inside the `fixedp` interface port `g`):
- g.clk  input  1  clock, rising edge
- g.reset  input  1  reset, synchronous, active-high
- en  input  1  advance; 0 freezes every stage
- flush  input  1  synchronous clear of all in-flight entries
- lat  input  LW=$clog2(MAX_DELAY+1)  requested latency
- i_valid  input  WIDTH  entry valid bits
- i_tag  input  TAG_W  entry tag
- o_valid  output  WIDTH  delayed valid
- o_tag  output  TAG_W  delayed tag, 0 when o_valid==0
- count  output  LW  entries in flight (stages 1..lat_cur holding nonzero valid)
- busy  output  1  count != 0
- lat_cur  output  LW  latency in effect
- lat_pending  output  1  min(lat,MAX_DELAY) != lat_cur
- lat_err  output  1  sticky: lat > MAX_DELAY was seen

## Operation
- Storage: stages 1..MAX_DELAY, each holding {valid[WIDTH], tag[TAG_W]}.
- On an advance edge (en=1, no flush, no reset):
  - stage1 <= {i_valid, i_tag};
  - stage[k+1] <= stage[k] for k < lat_cur;
  - stage[k+1] <= 0 for k ≥ lat_cur, so tapped entries are consumed and never re-emerge if the latency grows.
- en=0: all stages hold.
  - o_valid = 0; o_tag = 0.
  - i_valid is not accepted.
- Output tap:
  - lat_cur = 0: o_valid = i_valid & {WIDTH{en}}, o_tag = i_tag when o_valid≠0, else 0 (combinational).
  - lat_cur ≥ 1: o_valid = stage[lat_cur].valid & {WIDTH{en}}.
- An entry counts only if its valid vector is nonzero. Entries with an all-zero valid are bubbles.
- count:
  - +1 when a nonzero i_valid is accepted with lat_cur ≥ 1;
  - −1 when en=1 and stage[lat_cur] is nonzero;
  - both in the same cycle: unchanged.
- flush:
  - clears every stage valid and count to 0;
  - same-cycle i_valid is dropped;
  - same-cycle o_valid still presents the current tap (combinational).
  - flush works regardless of en.
- Latency update: lat_cur <= min(lat, MAX_DELAY) on any edge where count==0 after that edge's update (including the flush edge), regardless of en.
  - A nonzero entry accepted on the switch edge uses the new latency.
  - While busy, the request waits; lat_pending=1.
- lat_err sets on any edge where lat > MAX_DELAY. It is cleared only by reset.
- Reset: all stages 0, count 0, lat_cur=DEFAULT_LAT, lat_err 0.

## Timing
- Reset values:
  - o_valid=0, o_tag=0, count=0, busy=0, lat_cur=DEFAULT_LAT, lat_err=0;
  - lat_pending follows lat combinationally.
- Latency: an entry accepted at cycle t appears on o_valid/o_tag in the cycle of the lat_cur-th subsequent en=1 cycle. With continuous en that is cycle t+lat_cur.
- Throughput: one entry per en=1 cycle, no bubbles inserted.
- count, busy, lat_cur, lat_err are registered, updating one edge after the cause. o_valid/o_tag are combinational from stage regs and en.
- Reset mid-stream: all in-flight entries are lost, nothing emerges afterward. Same for flush.
- Reset overrides flush and en.

## Test plan
- Reset, lat=4, en=1, valid with tags 0x11,0x22,0x33 on cycles 0..2 -> o_valid=1 with o_tag 0x11,0x22,0x33 on cycles 4..6; count peaks at 3 and returns to 0.
- Same stream, en=0 on cycles 2 and 5 -> each output shifts by the number of stalled cycles; o_valid=0 during stalls; no loss or duplication.
- lat changed 4->8 while busy -> lat_pending=1, in-flight entries still exit at 4; lat_cur=8 on the edge count hits 0; next entry exits after 8.
- lat=0 -> o_valid/o_tag equal i_valid/i_tag same cycle; count stays 0. Then lat=MAX_DELAY+3 -> lat_err=1, lat_cur=MAX_DELAY.
- flush with 3 entries in flight plus a simultaneous new valid -> count=0 next cycle; no further o_valid.
- Shrink 8->2 with stale bubbles in deep stages, then grow 2->8 -> no phantom outputs appear.
